// File: rtl/sobel5_stream.sv
// Streaming 5x5 Sobel (Gy/Gx/|Gx|+|Gy|) over raster pixels; SOBEL5_THRESH_EN turns the output into a binary edge map.
// Latency 3 clk from the window-completing beat; no backpressure, input gaps become output gaps.
module sobel5_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ACC_W = PIX_W + 8
`ifdef SOBEL5_THRESH_EN
  , parameter int THRESH = 2 ** (PIX_W - 1)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [ACC_W:0] MAXV = {{(ACC_W + 1 - PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic [CW-1:0] col_q, col_c, col_nx;
  logic [RW-1:0] row_q, row_c, row_nx;
  logic          win_ok, win_first, win_last;
  logic [1:0]    mode_q, mode_in;

  logic [PIX_W-1:0] lb   [4][IMG_W];
  logic [PIX_W-1:0] live [5];
  logic [PIX_W-1:0] win  [5][5];

  logic             s1_vld, s1_sof, s1_eof;
  logic [1:0]       s1_mode;
  logic signed [ACC_W-1:0] wx   [5][5];
  logic signed [ACC_W-1:0] rp_n [5];
  logic signed [ACC_W-1:0] cp_n [5];
  logic signed [ACC_W-1:0] rp_q [5];
  logic signed [ACC_W-1:0] cp_q [5];
  logic             s2_vld, s2_sof, s2_eof;
  logic [1:0]       s2_mode;

  logic signed [ACC_W-1:0] gx, gy;
  logic [ACC_W-1:0] agx, agy;
  logic [ACC_W:0]   mag;
  logic [PIX_W-1:0] res;

  // SOF overrides the running position so a partial frame is simply abandoned
  always_comb begin
    col_c = in_sof ? '0 : col_q;
    row_c = in_sof ? '0 : row_q;
    if (col_c == COL_LAST) begin
      col_nx = '0;
      row_nx = (row_c == ROW_LAST) ? '0 : row_c + RW'(1);
    end else begin
      col_nx = col_c + CW'(1);
      row_nx = row_c;
    end
    win_ok    = (row_c >= RW'(4)) && (col_c >= CW'(4));
    win_first = (row_c == RW'(4)) && (col_c == CW'(4));
    win_last  = (row_c == ROW_LAST) && (col_c == COL_LAST);
    mode_in   = (mode == 2'd3) ? 2'd0 : mode;
  end

  // window row 0 is the oldest line, row 4 the live pixel
  always_comb begin
    live[4] = in_pixel;
    live[3] = lb[0][col_c];
    live[2] = lb[1][col_c];
    live[1] = lb[2][col_c];
    live[0] = lb[3][col_c];
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb[0][col_c] <= in_pixel;
      for (int i = 1; i < 4; i++) lb[i][col_c] <= lb[i-1][col_c];
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win[r][c] <= win[r][c+1];
        win[r][4] <= live[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        wx[r][c] = $signed({{(ACC_W - PIX_W){1'b0}}, win[r][c]});
    for (int i = 0; i < 5; i++) begin
      rp_n[i] = wx[i][0] + (wx[i][1] <<< 2) + (wx[i][2] <<< 2) + (wx[i][2] <<< 1)
              + (wx[i][3] <<< 2) + wx[i][4];
      cp_n[i] = wx[0][i] + (wx[1][i] <<< 2) + (wx[2][i] <<< 2) + (wx[2][i] <<< 1)
              + (wx[3][i] <<< 2) + wx[4][i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      rp_q[i] <= rp_n[i];
      cp_q[i] <= cp_n[i];
    end
  end

  always_comb begin
    gy  = (rp_q[4] + (rp_q[3] <<< 1)) - (rp_q[0] + (rp_q[1] <<< 1));
    gx  = (cp_q[4] + (cp_q[3] <<< 1)) - (cp_q[0] + (cp_q[1] <<< 1));
    agy = gy[ACC_W-1] ? $unsigned(-gy) : $unsigned(gy);
    agx = gx[ACC_W-1] ? $unsigned(-gx) : $unsigned(gx);
    case (s2_mode)
      2'd1:    mag = {1'b0, agx} >> 4;
      2'd2:    mag = ({1'b0, agx} + {1'b0, agy}) >> 5;
      default: mag = {1'b0, agy} >> 4;
    endcase
`ifdef SOBEL5_THRESH_EN
    res = (mag >= (ACC_W + 1)'(THRESH)) ? '1 : '0;
`else
    res = (mag > MAXV) ? '1 : mag[PIX_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= '0;
      s1_vld    <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      s1_mode   <= '0;
      s2_vld    <= 1'b0;
      s2_sof    <= 1'b0;
      s2_eof    <= 1'b0;
      s2_mode   <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (in_valid) begin
        col_q <= col_nx;
        row_q <= row_nx;
        if (in_sof) mode_q <= mode_in;
      end
      // the SOF beat itself never completes a window, so the old mode_q is harmless here
      s1_vld    <= in_valid && win_ok;
      s1_sof    <= in_valid && win_first;
      s1_eof    <= in_valid && win_last;
      s1_mode   <= mode_q;
      s2_vld    <= s1_vld;
      s2_sof    <= s1_sof;
      s2_eof    <= s1_eof;
      s2_mode   <= s1_mode;
      out_valid <= s2_vld;
      out_pixel <= s2_vld ? res : '0;
      out_sof   <= s2_sof;
      out_eof   <= s2_eof;
    end
  end

endmodule

// File: tb/tb_sobel5_stream.sv
// Randomized scoreboard bench for sobel5_stream on an 8x8 frame against a direct convolution model.
module tb_sobel5_stream;

  localparam int PW = 8;
  localparam int W  = 8;
  localparam int H  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic [1:0]    mode = '0;
  logic          out_valid;
  logic [PW-1:0] out_pixel;
  logic          out_sof;
  logic          out_eof;

  sobel5_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .mode(mode), .out_valid(out_valid),
    .out_pixel(out_pixel), .out_sof(out_sof), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int pix;
    int sof;
    int eof;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   img[H][W];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  task automatic chk(string name, int act, int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic int ref_pix(int cr, int cc, int m);
    int k[5] = '{1, 4, 6, 4, 1};
    int d[5] = '{-1, -2, 0, 2, 1};
    int gx = 0, gy = 0, ax, ay, v;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        gy += d[r] * k[c] * img[cr-2+r][cc-2+c];
        gx += k[r] * d[c] * img[cr-2+r][cc-2+c];
      end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (m)
      1:       v = ax / 16;
      2:       v = (ax + ay) / 32;
      default: v = ay / 16;
    endcase
    if (v > 255) v = 255;
`ifdef SOBEL5_THRESH_EN
    v = (v >= 128) ? 255 : 0;
`endif
    return v;
  endfunction

  // kind 0: flat 100, 1: rows 4..7 = 200, 2: cols 4..7 = 200, else random
  task automatic fill(int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r >= 4) ? 200 : 0;
          2:       img[r][c] = (c >= 4) ? 200 : 0;
          default: img[r][c] = $urandom_range(0, 255);
        endcase
  endtask

  task automatic beat(int r, int c, int m, bit sof);
    exp_t e;
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = PW'(img[r][c]);
    mode     = sof ? 2'(m) : 2'($urandom_range(0, 3));
    if (r >= 4 && c >= 4) begin
      e.pix = ref_pix(r - 2, c - 2, m);
      e.sof = int'(r == 4 && c == 4);
      e.eof = int'(r == H - 1 && c == W - 1);
      e.cyc = cyc + 3;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle();
    mode = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
  endtask

  // gaps 0: back-to-back, 1: alternate idle cycles, 2: random idle cycles
  task automatic send_frame(int m, int gaps, int npix);
    for (int i = 0; i < npix; i++) begin
      beat(i / W, i % W, m, i == 0);
      if (gaps == 1) idle();
      else if (gaps == 2 && $urandom_range(0, 3) == 0) idle();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("pixel", int'(out_pixel), e.pix);
        chk("sof", int'(out_sof), e.sof);
        chk("eof", int'(out_eof), e.eof);
        chk("latency_cycle", cyc, e.cyc);
      end
    end else if (out_sof || out_eof) begin
      chk("flag_without_valid", int'(out_sof | out_eof), 0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    chk("rst_out_eof", int'(out_eof), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill(0); send_frame(0, 0, 64);
    fill(1); send_frame(0, 0, 64);
    send_frame(1, 0, 64);
    send_frame(2, 0, 64);
    fill(2); send_frame(1, 0, 64);
    fill(1); send_frame(0, 1, 64);
    send_frame(2, 1, 64);
    fill(2); send_frame(1, 1, 64);
    fill(3); send_frame(3, 0, 64);
    repeat (3) begin
      fill(3);
      send_frame($urandom_range(0, 3), 2, 64);
    end

    // SOF arrives mid-frame after some windows have already been produced
    fill(3); send_frame(2, 2, 50);
    fill(3); send_frame(1, 0, 64);

    // async reset mid-frame discards in-flight results
    fill(3); send_frame(0, 0, 45);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_pixel", int'(out_pixel), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) idle();
    fill(3); send_frame(2, 0, 64);

    repeat (10) @(posedge clk);
    #1;
    chk("drain_outstanding", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
